// File: rtl/acc16_pkg.sv
// Shared types and constants for the acc16_stream frame accumulator.
package acc16_pkg;

  localparam int DATA_W        = 16;
  localparam int MAX_WORDS_DEF = 16;
  localparam int CNT_W_DEF     = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/acc16_stream_if.sv
// Input word stream and output frame-result stream of acc16_stream.
interface acc16_stream_if #(
  parameter int CNT_W = acc16_pkg::CNT_W_DEF
);
  import acc16_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_sum;
  logic                out_carry;
  logic [CNT_W-1:0]    out_count;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_count
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_count
  );

endinterface

// File: rtl/acc16_stream_add16.sv
// 16-bit adder built from four 4-bit carry-lookahead groups (add4 -> add16).
module add4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_s,
  output logic       o_cout
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_s    = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];
endmodule

module add16
  import acc16_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_cin,
  output logic [DATA_W-1:0] o_s,
  output logic              o_cout
);
  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < 4; g++) begin : g_grp
    add4 u_add4 (
      .i_a    (i_a[4*g +: 4]),
      .i_b    (i_b[4*g +: 4]),
      .i_cin  (w_c[g]),
      .o_s    (o_s[4*g +: 4]),
      .o_cout (w_c[g+1])
    );
  end

  assign o_cout = w_c[4];
endmodule

// File: rtl/acc16_stream.sv
// Frame accumulator: sums a valid/ready word stream per frame through add16 and
// presents the sum, sticky carry and word count on a registered result port.
module acc16_stream
  import acc16_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  acc16_stream_if.slave bus
);
  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_acc;
  logic                r_carry;
  logic [CNT_W-1:0]    r_count;
  logic [DATA_W-1:0]   r_out_sum;
  logic                r_out_carry;
  logic [CNT_W-1:0]    r_out_count;
  logic                r_out_valid;
  logic                r_in_ready;

  logic [DATA_W-1:0]   w_sum;
  logic                w_cout;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_beat;
  logic                w_close;
  logic                w_out_hs;

  add16 u_add16 (
    .i_a    (r_acc),
    .i_b    (bus.in_data),
    .i_cin  (1'b0),
    .o_s    (w_sum),
    .o_cout (w_cout)
  );

  assign w_beat    = bus.in_valid & r_in_ready;
  assign w_cnt_nxt = r_count + CNT_W'(1);
  assign w_close   = w_beat & (bus.in_last | (w_cnt_nxt == CNT_W'(MAX_WORDS)));
  assign w_out_hs  = r_out_valid & bus.out_ready;

  // Next-state decode for the frame control FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_close)     w_state_nxt = ST_HOLD;
        else if (w_beat) w_state_nxt = ST_ACC;
        else             w_state_nxt = ST_IDLE;
      end
      ST_ACC: begin
        if (w_close) w_state_nxt = ST_HOLD;
        else         w_state_nxt = ST_ACC;
      end
      ST_HOLD: begin
        if (w_out_hs) w_state_nxt = ST_IDLE;
        else          w_state_nxt = ST_HOLD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus handshake flags, both derived from the next state so
  // neither ready nor valid has a combinational path from the other side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_HOLD);
      r_out_valid <= (w_state_nxt == ST_HOLD);
    end
  end

  // Running accumulator; cleared when the held result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= 16'h0000;
      r_carry <= 1'b0;
      r_count <= {CNT_W{1'b0}};
    end else if (w_out_hs) begin
      r_acc   <= 16'h0000;
      r_carry <= 1'b0;
      r_count <= {CNT_W{1'b0}};
    end else if (w_beat) begin
      r_acc   <= w_sum;
      r_carry <= r_carry | w_cout;
      r_count <= w_cnt_nxt;
    end else begin
      r_acc   <= r_acc;
      r_carry <= r_carry;
      r_count <= r_count;
    end
  end

  // Result registers capture post-beat values on the closing beat only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_sum   <= 16'h0000;
      r_out_carry <= 1'b0;
      r_out_count <= {CNT_W{1'b0}};
    end else if (w_close) begin
      r_out_sum   <= w_sum;
      r_out_carry <= r_carry | w_cout;
      r_out_count <= w_cnt_nxt;
    end else begin
      r_out_sum   <= r_out_sum;
      r_out_carry <= r_out_carry;
      r_out_count <= r_out_count;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_carry = r_out_carry;
  assign bus.out_count = r_out_count;
endmodule
